dnp3_link_rx: RTL and testbench
===============================

Name: dnp3_link_rx

Overview:
Parametrised DNP3 link-layer receiver, the successor to the single-address header parser. Takes the UART byte stream, hunts for 0x05 0x64, and parses the full frame. It checks the header CRC and every user-data block CRC, matches the destination against a list of NUM_ADDR addresses plus optional broadcast, and enforces an inter-byte timeout. It streams user data to the transport layer and keeps saturating frame and error counters for the status and LED logic.

Parameters:
NUM_ADDR, 2, number of accepted destination addresses (1..8)
ADDR_LIST, {16'h0002,16'h0001}, packed 16*NUM_ADDR list; entry i is bits [16i+15:16i]
ACCEPT_BCAST, 1, when 1, destinations 0xFFFD..0xFFFF match as broadcast
TIMEOUT_CYCLES, 12000, maximum idle cycles between bytes inside a frame (1 ms at 12 MHz)
CNT_W, 16, width of the frame and error counters

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
data_in  in  8  received byte
data_valid  in  1  one-cycle strobe; data_in is valid this cycle
frame_valid  out  1  one-cycle pulse: complete frame with all CRCs good
frame_error  out  1  one-cycle pulse: frame aborted
err_code  out  3  cause of the last frame_error; held until the next error
control  out  8  link control byte of the last parsed header
dest_addr  out  16  destination address (little-endian on the wire)
src_addr  out  16  source address
addr_match  out  1  dest hit ADDR_LIST or broadcast; valid with frame_valid
addr_index  out  3  index of the matching ADDR_LIST entry (0 for broadcast/no match)
bcast  out  1  dest is in 0xFFFD..0xFFFF and ACCEPT_BCAST=1
user_data  out  8  user-data byte, CRC bytes stripped
user_valid  out  1  one-cycle strobe for user_data
frame_cnt  out  CNT_W  saturating count of frame_valid pulses with addr_match=1
error_cnt  out  CNT_W  saturating count of frame_error pulses

Behaviour:
- Reset: all outputs 0, FSM to HUNT, CRC accumulator 0, timeout counter 0.
- CRC-16/DNP:
  - reflected polynomial 0xA6BC, init 0x0000, processed LSB first, final value complemented;
  - check value over ASCII "123456789" is 0xEA82;
  - on the wire, the CRC is sent low byte first.
- FSM, advancing only on data_valid:
  - HUNT: 0x05 -> SYNC, CRC seeded with 0x05; any other byte stays in HUNT.
  - SYNC: 0x64 -> HDR; 0x05 -> stay in SYNC and reseed; any other byte -> HUNT. No error in SYNC.
  - HDR: 6 bytes in order LEN, CTRL, DEST lo, DEST hi, SRC lo, SRC hi.
    - If LEN < 5, raise the error when LEN arrives (err 2) and go to HUNT.
  - HCRC: 2 bytes compared against the CRC over the 8 header bytes.
    - Mismatch -> err 3, HUNT.
    - Match: latch control, dest_addr, src_addr, addr_match, addr_index, bcast.
    - Then if LEN == 5 -> DONE, else -> DATA with remaining = LEN-5.
  - DATA: block of min(16, remaining) bytes; CRC is reseeded at the start of each block.
    - user_valid pulses on the cycle after each byte, only when addr_match=1.
  - DCRC: 2 bytes per block.
    - Mismatch -> err 4, HUNT.
    - Match -> DATA if remaining > 0, else DONE.
  - DONE: pulse frame_valid (regardless of match), return to HUNT.
- Latency: frame_valid/frame_error assert exactly 1 cycle after the data_valid of the triggering byte.
- addr_index: lowest matching index wins when ADDR_LIST has duplicates.
- Timeout:
  - The counter clears on every data_valid and runs in every state except HUNT.
  - On reaching TIMEOUT_CYCLES-1 with no data_valid that cycle: err 5, go to HUNT.
  - data_valid on that same cycle wins and the timeout does not fire.
- err_code values: 2 bad LEN, 3 header CRC, 4 data CRC, 5 timeout. 0 and 1 are unused/reserved.
- Counters:
  - frame_cnt increments on frame_valid && addr_match; error_cnt increments on frame_error.
  - Both saturate at all-ones and never wrap.
- frame_valid and frame_error never assert in the same cycle.
- Reset mid-frame: the frame is discarded with no error pulse, and the counters clear.

Test Plan:
- Valid header-only frame with LEN=5, dest 0x0001, correct CRC -> frame_valid 1 cycle after last byte; addr_match=1, addr_index=0, frame_cnt=1, no user_valid.
- Frame with LEN=0x17 (18 user bytes, blocks of 16+2), dest 0x0002 -> 18 user_valid strobes with the correct bytes, addr_index=1, frame_valid after the final CRC byte.
- Same frame with one data byte corrupted in block 2 -> frame_error, err_code=4, no frame_valid, error_cnt=1.
- Dest 0xFFFF with ACCEPT_BCAST=1, then dest 0x0009 -> first: bcast=1, addr_match=1; second: frame_valid with addr_match=0 and frame_cnt unchanged.
- Noise 0x05 0x05 0x64 followed by a valid frame, and LEN=0x03 -> valid frame accepted; LEN=3 gives err_code=2 one cycle after the LEN byte.
- Stall TIMEOUT_CYCLES after the CTRL byte -> err_code=5; bytes arriving exactly on the boundary cycle suppress the timeout; CRC unit gives 0xEA82 on "123456789".

Source files
------------

// File: rtl/dnp3_link_rx.sv
// dnp3_link_rx -- DNP3 link-layer frame receiver.
//
// Hunts the UART byte stream for the 0x05 0x64 start sequence, parses the
// 10-byte header, verifies the header CRC and every user-data block CRC
// (CRC-16/DNP), matches the destination against ADDR_LIST plus optional
// broadcast, enforces an inter-byte timeout, streams user data and keeps
// saturating frame/error counters.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   data_in        received byte, qualified by data_valid (1-cycle strobe)
//   frame_valid    1-cycle pulse: complete frame, all CRCs good
//   frame_error    1-cycle pulse: frame aborted, cause in err_code
//   err_code       2 bad LEN, 3 header CRC, 4 data CRC, 5 timeout (held)
//   control        link control byte of the last good header
//   dest_addr      destination of the last good header
//   src_addr       source of the last good header
//   addr_match     destination hit ADDR_LIST or broadcast
//   addr_index     lowest matching ADDR_LIST index (0 for broadcast/no hit)
//   bcast          destination in 0xFFFD..0xFFFF with ACCEPT_BCAST=1
//   user_data      user-data byte with CRC bytes stripped
//   user_valid     1-cycle strobe for user_data (only for matched frames)
//   frame_cnt      saturating count of matched good frames
//   error_cnt      saturating count of aborted frames
module dnp3_link_rx #(
    parameter int unsigned              NUM_ADDR       = 2,
    parameter logic [16*NUM_ADDR-1:0]   ADDR_LIST      = {16'h0002, 16'h0001},
    parameter bit                       ACCEPT_BCAST   = 1'b1,
    parameter int unsigned              TIMEOUT_CYCLES = 12000,
    parameter int unsigned              CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             frame_valid,
    output logic             frame_error,
    output logic [2:0]       err_code,
    output logic [7:0]       control,
    output logic [15:0]      dest_addr,
    output logic [15:0]      src_addr,
    output logic             addr_match,
    output logic [2:0]       addr_index,
    output logic             bcast,
    output logic [7:0]       user_data,
    output logic             user_valid,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] error_cnt
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ERR_LEN  = 3'd2;
    localparam logic [2:0] ERR_HCRC = 3'd3;
    localparam logic [2:0] ERR_DCRC = 3'd4;
    localparam logic [2:0] ERR_TO   = 3'd5;

    typedef enum logic [2:0] {
        S_HUNT, S_SYNC, S_HDR, S_HCRC, S_DATA, S_DCRC, S_DONE
    } state_t;

    state_t          state_q, state_n;
    logic [15:0]     crc_q, crc_n;
    logic [3:0]      byte_cnt_q;
    logic [7:0]      rem_q;
    logic [7:0]      len_q, ctrl_q, crc_lo_q;
    logic [15:0]     dst_q, src_q;
    logic [TW-1:0]   to_cnt_q;

    logic            timeout_hit;
    logic            crc_ok;
    logic            ev_fv, ev_fe, ev_hdr, ev_user;
    logic [2:0]      ev_err;
    logic            list_hit, bc_hit;
    logic [2:0]      list_idx;

    // Reflected CRC-16/DNP update, one byte, LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA6BC;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Received CRC arrives low byte first; the low byte is parked in crc_lo_q.
    assign crc_ok = ({data_in, crc_lo_q} == ~crc_q);

    // Idle counter is not armed in HUNT, nor in the single DONE cycle.
    assign timeout_hit = !data_valid && (state_q != S_HUNT) && (state_q != S_DONE)
                         && (to_cnt_q == TO_LAST);

    // Destination lookup: first (lowest) matching entry wins.
    always_comb begin
        list_hit = 1'b0;
        list_idx = '0;
        for (int unsigned i = 0; i < NUM_ADDR; i++) begin
            if (!list_hit && (dst_q == ADDR_LIST[16*i +: 16])) begin
                list_hit = 1'b1;
                list_idx = 3'(i);
            end
        end
    end

    assign bc_hit = ACCEPT_BCAST && (dst_q >= 16'hFFFD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_HUNT;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        crc_n   = crc_q;
        ev_fv   = 1'b0;
        ev_fe   = 1'b0;
        ev_err  = '0;
        ev_hdr  = 1'b0;
        ev_user = 1'b0;
        if (timeout_hit) begin
            ev_fe   = 1'b1;
            ev_err  = ERR_TO;
            state_n = S_HUNT;
        end else if (data_valid) begin
            unique case (state_q)
                // DONE lasts one cycle; a byte arriving then is treated as in HUNT
                S_HUNT, S_DONE: begin
                    if (data_in == 8'h05) begin
                        state_n = S_SYNC;
                        crc_n   = crc_byte(16'h0000, 8'h05);
                    end else begin
                        state_n = S_HUNT;
                    end
                end
                S_SYNC: begin
                    if (data_in == 8'h64) begin
                        state_n = S_HDR;
                        crc_n   = crc_byte(crc_q, data_in);
                    end else if (data_in == 8'h05) begin
                        crc_n   = crc_byte(16'h0000, 8'h05);
                    end else begin
                        state_n = S_HUNT;
                    end
                end
                S_HDR: begin
                    crc_n = crc_byte(crc_q, data_in);
                    if ((byte_cnt_q == 4'd0) && (data_in < 8'd5)) begin
                        ev_fe   = 1'b1;
                        ev_err  = ERR_LEN;
                        state_n = S_HUNT;
                    end else if (byte_cnt_q == 4'd5) begin
                        state_n = S_HCRC;
                    end
                end
                S_HCRC: begin
                    if (byte_cnt_q == 4'd1) begin
                        if (crc_ok) begin
                            ev_hdr = 1'b1;
                            if (len_q == 8'd5) begin
                                state_n = S_DONE;
                                ev_fv   = 1'b1;
                            end else begin
                                state_n = S_DATA;
                                crc_n   = '0;
                            end
                        end else begin
                            ev_fe   = 1'b1;
                            ev_err  = ERR_HCRC;
                            state_n = S_HUNT;
                        end
                    end
                end
                S_DATA: begin
                    crc_n   = crc_byte(crc_q, data_in);
                    ev_user = addr_match;
                    if ((byte_cnt_q == 4'd15) || (rem_q == 8'd1)) state_n = S_DCRC;
                end
                S_DCRC: begin
                    if (byte_cnt_q == 4'd1) begin
                        if (!crc_ok) begin
                            ev_fe   = 1'b1;
                            ev_err  = ERR_DCRC;
                            state_n = S_HUNT;
                        end else if (rem_q == 8'd0) begin
                            state_n = S_DONE;
                            ev_fv   = 1'b1;
                        end else begin
                            state_n = S_DATA;
                            crc_n   = '0;
                        end
                    end
                end
                default: state_n = S_HUNT;
            endcase
        end else if (state_q == S_DONE) begin
            state_n = S_HUNT;
        end
    end

    // Parsing datapath: CRC accumulator, byte position, header shadows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q      <= '0;
            byte_cnt_q <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            ctrl_q     <= '0;
            crc_lo_q   <= '0;
            dst_q      <= '0;
            src_q      <= '0;
            to_cnt_q   <= '0;
        end else begin
            crc_q <= crc_n;

            // byte_cnt_q is the byte position within the current state
            if (state_n != state_q) byte_cnt_q <= '0;
            else if (data_valid)    byte_cnt_q <= byte_cnt_q + 4'd1;

            if (data_valid) begin
                unique case (state_q)
                    S_HDR: begin
                        unique case (byte_cnt_q)
                            4'd0:    len_q       <= data_in;
                            4'd1:    ctrl_q      <= data_in;
                            4'd2:    dst_q[7:0]  <= data_in;
                            4'd3:    dst_q[15:8] <= data_in;
                            4'd4:    src_q[7:0]  <= data_in;
                            4'd5:    src_q[15:8] <= data_in;
                            default: ;
                        endcase
                    end
                    S_HCRC, S_DCRC: if (byte_cnt_q == 4'd0) crc_lo_q <= data_in;
                    S_DATA:         rem_q <= rem_q - 8'd1;
                    default: ;
                endcase
            end
            if (ev_hdr) rem_q <= len_q - 8'd5;

            if (data_valid || timeout_hit || (state_q == S_HUNT) || (state_q == S_DONE))
                to_cnt_q <= '0;
            else
                to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    // Registered outputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            err_code    <= '0;
            control     <= '0;
            dest_addr   <= '0;
            src_addr    <= '0;
            addr_match  <= 1'b0;
            addr_index  <= '0;
            bcast       <= 1'b0;
            user_data   <= '0;
            user_valid  <= 1'b0;
            frame_cnt   <= '0;
            error_cnt   <= '0;
        end else begin
            frame_valid <= ev_fv;
            frame_error <= ev_fe;
            user_valid  <= ev_user;
            if (ev_fe)   err_code  <= ev_err;
            if (ev_user) user_data <= data_in;
            if (ev_hdr) begin
                control    <= ctrl_q;
                dest_addr  <= dst_q;
                src_addr   <= src_q;
                addr_match <= list_hit || bc_hit;
                addr_index <= list_idx;
                bcast      <= bc_hit;
            end
            if (frame_valid && addr_match && (frame_cnt != '1))
                frame_cnt <= frame_cnt + CNT_W'(1);
            if (frame_error && (error_cnt != '1))
                error_cnt <= error_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dnp3_link_rx.sv
// Scoreboard bench for dnp3_link_rx: stimulus pushes expected output events,
// a monitor pops and compares them as the DUT presents them.
module tb_dnp3_link_rx;

    localparam int T = 12000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_in = '0;
    logic        data_valid = 1'b0;

    logic        frame_valid, frame_error, addr_match, bcast, user_valid;
    logic [2:0]  err_code, addr_index;
    logic [7:0]  control, user_data;
    logic [15:0] dest_addr, src_addr, frame_cnt, error_cnt;

    logic        s_fv, s_fe, s_am, s_bc, s_uv;
    logic [2:0]  s_ec, s_ai;
    logic [7:0]  s_ctl, s_ud;
    logic [15:0] s_da, s_sa;
    logic [1:0]  s_fcnt, s_ecnt;

    dnp3_link_rx dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .frame_valid(frame_valid), .frame_error(frame_error), .err_code(err_code),
        .control(control), .dest_addr(dest_addr), .src_addr(src_addr),
        .addr_match(addr_match), .addr_index(addr_index), .bcast(bcast),
        .user_data(user_data), .user_valid(user_valid),
        .frame_cnt(frame_cnt), .error_cnt(error_cnt)
    );

    // Narrow-counter instance to reach counter saturation quickly.
    dnp3_link_rx #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .frame_valid(s_fv), .frame_error(s_fe), .err_code(s_ec),
        .control(s_ctl), .dest_addr(s_da), .src_addr(s_sa),
        .addr_match(s_am), .addr_index(s_ai), .bcast(s_bc),
        .user_data(s_ud), .user_valid(s_uv),
        .frame_cnt(s_fcnt), .error_cnt(s_ecnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int last_cyc = 0;

    typedef struct {
        int          kind;   // 0 user byte, 1 frame_valid, 2 frame_error
        int          cyc;
        logic [7:0]  b;
        logic [7:0]  ctrl;
        logic [15:0] dst;
        logic [15:0] src;
        logic        m;
        logic [2:0]  idx;
        logic        bc;
        logic [2:0]  err;
    } ev_t;

    ev_t sb[$];

    // ---------------- CRC model: MSB-first form of CRC-16/DNP ----------------
    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {rev8(b), 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h3D65) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] crc_fin(input logic [15:0] c);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = c[15-i];
        return ~r;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        data_in    = b;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        last_cyc   = cyc;
        data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic push_user(input logic [7:0] b);
        ev_t e;
        e = '{kind: 0, cyc: last_cyc, b: b, ctrl: 8'h00, dst: 16'h0, src: 16'h0,
              m: 1'b0, idx: 3'd0, bc: 1'b0, err: 3'd0};
        sb.push_back(e);
    endtask

    task automatic push_fv(input logic [7:0] ctrl, input logic [15:0] dst, input logic [15:0] src,
                           input logic m, input logic [2:0] idx, input logic bc);
        ev_t e;
        e = '{kind: 1, cyc: last_cyc, b: 8'h00, ctrl: ctrl, dst: dst, src: src,
              m: m, idx: idx, bc: bc, err: 3'd0};
        sb.push_back(e);
    endtask

    task automatic push_fe(input logic [2:0] err, input int at);
        ev_t e;
        e = '{kind: 2, cyc: at, b: 8'h00, ctrl: 8'h00, dst: 16'h0, src: 16'h0,
              m: 1'b0, idx: 3'd0, bc: 1'b0, err: err};
        sb.push_back(e);
    endtask

    // Sends one frame and queues what the receiver must report for it.
    // corrupt: user-byte index to flip on the wire (-1 none).
    // stall_before/stall_cycles: idle cycles inserted before header byte n.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] ctrl,
                              input logic [15:0] dst, input logic [15:0] src,
                              input logic ex_m, input logic [2:0] ex_idx, input logic ex_bc,
                              input int corrupt, input bit bad_hcrc,
                              input int stall_before, input int stall_cycles);
        logic [7:0]  h [8];
        logic [15:0] c;
        logic [7:0]  b, w;
        int          n, pos, blk;
        bit          hit;
        h[0] = 8'h05; h[1] = 8'h64; h[2] = len; h[3] = ctrl;
        h[4] = dst[7:0]; h[5] = dst[15:8]; h[6] = src[7:0]; h[7] = src[15:8];
        c = '0;
        for (int i = 0; i < 8; i++) c = crc_step(c, h[i]);
        c = crc_fin(c);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_before) idle(stall_cycles);
            put(h[i]);
            if (i == 2 && len < 8'd5) begin
                push_fe(3'd2, last_cyc);
                return;
            end
        end
        put(bad_hcrc ? (c[7:0] ^ 8'h01) : c[7:0]);
        put(c[15:8]);
        if (bad_hcrc) begin
            push_fe(3'd3, last_cyc);
            return;
        end
        n   = int'(len) - 5;
        pos = 0;
        while (pos < n) begin
            blk = (n - pos > 16) ? 16 : (n - pos);
            c   = '0;
            hit = 1'b0;
            for (int j = 0; j < blk; j++) begin
                b = 8'(8'h11 * (pos + j + 1));
                c = crc_step(c, b);
                w = b;
                if (pos + j == corrupt) begin
                    w   = b ^ 8'h10;
                    hit = 1'b1;
                end
                put(w);
                if (ex_m) push_user(w);
            end
            c = crc_fin(c);
            put(c[7:0]);
            put(c[15:8]);
            if (hit) begin
                push_fe(3'd4, last_cyc);
                return;
            end
            pos += blk;
        end
        push_fv(ctrl, dst, src, ex_m, ex_idx, ex_bc);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid && frame_error) begin
                tests++;
                fails++;
                $display("FAIL fv_fe_overlap: both pulses high at cycle %0d", cyc);
            end
            if (user_valid || frame_valid || frame_error) begin
                ev_t e;
                int  k;
                k = user_valid ? 0 : (frame_valid ? 1 : 2);
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: kind %0d at cycle %0d, nothing expected", k, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != k || e.cyc != cyc) begin
                        fails++;
                        $display("FAIL event_timing: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                                 k, cyc, e.kind, e.cyc);
                    end else if (k == 0 && user_data !== e.b) begin
                        fails++;
                        $display("FAIL user_data: got %02h expected %02h", user_data, e.b);
                    end else if (k == 1 && {control, dest_addr, src_addr, addr_match, addr_index, bcast}
                                        !== {e.ctrl, e.dst, e.src, e.m, e.idx, e.bc}) begin
                        fails++;
                        $display("FAIL frame_fields: got ctl %02h dst %04h src %04h m %0b idx %0d bc %0b expected ctl %02h dst %04h src %04h m %0b idx %0d bc %0b",
                                 control, dest_addr, src_addr, addr_match, addr_index, bcast,
                                 e.ctrl, e.dst, e.src, e.m, e.idx, e.bc);
                    end else if (k == 2 && err_code !== e.err) begin
                        fails++;
                        $display("FAIL err_code: got %0d expected %0d", err_code, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] s9 [9];
        logic [15:0] c;
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = '0;
        for (int i = 0; i < 9; i++) c = crc_step(c, s9[i]);
        chk("crc_model_check_value", 32'(crc_fin(c)), 32'hEA82);

        idle(3);
        @(negedge clk);
        chk("rst_pulses",   {frame_valid, frame_error, user_valid}, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_fields",   {control, dest_addr, src_addr, addr_match, addr_index, bcast, user_data}, 0);
        chk("rst_counters", {frame_cnt, error_cnt}, 0);
        rst_n = 1'b1;
        idle(2);

        // Header-only frame to address entry 0.
        send_frame(8'h05, 8'hC0, 16'h0001, 16'h0400, 1'b1, 3'd0, 1'b0, -1, 0, -1, 0);
        idle(3);
        chk("frame_cnt_1", frame_cnt, 1);
        chk("error_cnt_0", error_cnt, 0);

        // 18 user bytes in blocks of 16 + 2 to address entry 1.
        send_frame(8'h17, 8'h44, 16'h0002, 16'h0003, 1'b1, 3'd1, 1'b0, -1, 0, -1, 0);
        idle(3);
        chk("frame_cnt_2", frame_cnt, 2);

        // Same frame, byte 17 (second block) corrupted.
        send_frame(8'h17, 8'h44, 16'h0002, 16'h0003, 1'b1, 3'd1, 1'b0, 17, 0, -1, 0);
        idle(3);
        chk("dcrc_err_code", err_code, 4);
        chk("error_cnt_1", error_cnt, 1);
        chk("frame_cnt_hold_2", frame_cnt, 2);

        // Broadcast, then unmatched destinations (no user strobes, no count).
        send_frame(8'h05, 8'hC4, 16'hFFFF, 16'h0400, 1'b1, 3'd0, 1'b1, -1, 0, -1, 0);
        idle(3);
        chk("frame_cnt_bcast", frame_cnt, 3);
        send_frame(8'h05, 8'hC4, 16'h0009, 16'h0400, 1'b0, 3'd0, 1'b0, -1, 0, -1, 0);
        send_frame(8'h08, 8'h44, 16'h0009, 16'h0400, 1'b0, 3'd0, 1'b0, -1, 0, -1, 0);
        idle(3);
        chk("frame_cnt_nomatch", frame_cnt, 3);

        // Noise and repeated 0x05 before a valid frame.
        put(8'h05); put(8'h13); put(8'h05); put(8'h05);
        send_frame(8'h05, 8'hC0, 16'h0001, 16'h0400, 1'b1, 3'd0, 1'b0, -1, 0, -1, 0);
        idle(3);
        chk("frame_cnt_after_noise", frame_cnt, 4);

        // LEN below minimum.
        send_frame(8'h03, 8'hC0, 16'h0001, 16'h0400, 1'b1, 3'd0, 1'b0, -1, 0, -1, 0);
        idle(3);
        chk("len_err_code", err_code, 2);

        // Header CRC error.
        send_frame(8'h05, 8'hC0, 16'h0001, 16'h0400, 1'b1, 3'd0, 1'b0, -1, 1, -1, 0);
        idle(3);
        chk("hcrc_err_code", err_code, 3);
        chk("error_cnt_3", error_cnt, 3);

        // Stall after CTRL: fires TIMEOUT_CYCLES cycles after that byte.
        put(8'h05); put(8'h64); put(8'h05); put(8'hC0);
        push_fe(3'd5, last_cyc + T);
        idle(T + 4);
        chk("timeout_err_code", err_code, 5);
        chk("error_cnt_4", error_cnt, 4);

        // Next byte lands exactly on the boundary cycle: no timeout.
        send_frame(8'h05, 8'hC0, 16'h0001, 16'h0400, 1'b1, 3'd0, 1'b0, -1, 0, 4, T - 1);
        idle(3);
        chk("frame_cnt_boundary", frame_cnt, 5);
        chk("error_cnt_boundary", error_cnt, 4);
        chk("sat_frame_cnt", s_fcnt, 3);
        chk("sat_error_cnt", s_ecnt, 3);

        // Reset mid-frame: discarded silently, counters cleared.
        put(8'h05); put(8'h64); put(8'h0A); put(8'hC0); put(8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        @(negedge clk);
        chk("midrst_counters", {frame_cnt, error_cnt, s_fcnt, s_ecnt}, 0);
        chk("midrst_err_code", err_code, 0);
        rst_n = 1'b1;
        idle(5);
        send_frame(8'h05, 8'hC0, 16'h0002, 16'h0400, 1'b1, 3'd1, 1'b0, -1, 0, -1, 0);
        idle(3);
        chk("frame_cnt_after_reset", frame_cnt, 1);
        chk("error_cnt_after_reset", error_cnt, 0);

        idle(5);
        while (sb.size() > 0) begin
            ev_t e;
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_event: kind %0d expected at cycle %0d never seen", e.kind, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
